// File: rtl/avalon_pio_input_irq.sv
// Avalon-MM input port: 2-flop synchroniser, per-bit debounce, edge capture
// and maskable interrupt. Read data is registered (one-cycle read latency).
module avalon_pio_input_irq #(
  parameter int WIDTH           = 18,
  parameter int DEBOUNCE_CYCLES = 1,
  parameter int EDGE_TYPE       = 0,
  parameter int IRQ_TYPE        = 1,
  parameter int BIT_CLEAR       = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_d;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecapture;
  logic [WIDTH-1:0] ev;
  logic [WIDTH-1:0] ecap_clr;
  logic [WIDTH-1:0] wd;
  logic [CNT_W-1:0] cnt [WIDTH];
  logic [31:0]      rd_next;
  logic             wr_en;
  logic             unused_writedata;

  assign wr_en            = chipselect && !write_n;
  assign wd               = writedata[WIDTH-1:0];
  assign unused_writedata = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
    end
  end

  // A bit is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable <= '0;
      for (int unsigned i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    ev = '0;
    case (EDGE_TYPE)
      0:       ev = stable & ~stable_d;
      1:       ev = ~stable & stable_d;
      default: ev = stable ^ stable_d;
    endcase
  end

  always_comb begin
    ecap_clr = '0;
    if (wr_en && address == 2'd3) ecap_clr = (BIT_CLEAR != 0) ? wd : '1;
  end

  // Set is OR-ed in after the clear so a same-cycle event always survives.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_d    <= '0;
      edgecapture <= '0;
      irqmask     <= '0;
    end else begin
      stable_d    <= stable;
      edgecapture <= (edgecapture & ~ecap_clr) | ev;
      if (wr_en && address == 2'd2) irqmask <= wd;
    end
  end

  always_comb begin
    rd_next = '0;
    case (address)
      2'd0:    rd_next[WIDTH-1:0] = stable;
      2'd2:    rd_next[WIDTH-1:0] = irqmask;
      2'd3:    rd_next[WIDTH-1:0] = edgecapture;
      default: rd_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_next;
  end

  assign irq = (IRQ_TYPE == 1) ? |(edgecapture & irqmask) : |(stable & irqmask);

endmodule

// File: tb/tb_avalon_pio_input_irq.sv
// Bench for avalon_pio_input_irq: three parameter variants on a shared bus,
// checked every cycle against a sample-history model plus literal expectations.
module tb_avalon_pio_input_irq;

  localparam int W = 18;

  logic          clk        = 1'b0;
  logic          reset_n    = 1'b0;
  logic [1:0]    address    = '0;
  logic          chipselect = 1'b0;
  logic          write_n    = 1'b1;
  logic [31:0]   writedata  = '0;
  logic [W-1:0]  in_a = '0, in_b = '0, in_c = '0;
  logic [31:0]   rd_a, rd_b, rd_c;
  logic          irq_a, irq_b, irq_c;

  always #5 clk = ~clk;

  avalon_pio_input_irq #(.WIDTH(W), .DEBOUNCE_CYCLES(1), .EDGE_TYPE(0), .IRQ_TYPE(1), .BIT_CLEAR(1)) u_a (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_a), .readdata(rd_a), .irq(irq_a));

  avalon_pio_input_irq #(.WIDTH(W), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0), .IRQ_TYPE(1), .BIT_CLEAR(1)) u_b (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_b), .readdata(rd_b), .irq(irq_b));

  avalon_pio_input_irq #(.WIDTH(W), .DEBOUNCE_CYCLES(1), .EDGE_TYPE(2), .IRQ_TYPE(0), .BIT_CLEAR(0)) u_c (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_c), .readdata(rd_c), .irq(irq_c));

  int dbn [3] = '{1, 4, 1};
  int et  [3] = '{0, 0, 2};
  int it  [3] = '{1, 1, 0};
  int bc  [3] = '{1, 1, 0};

  // hist[i][0] is the most recent in_port sample; hist[i][k] is k samples older.
  logic [W-1:0] hist   [3][8];
  logic [W-1:0] m_st   [3];
  logic [W-1:0] m_std  [3];
  logic [W-1:0] m_mask [3];
  logic [W-1:0] m_ecap [3];
  logic [31:0]  m_rd   [3];

  int errors = 0;
  int checks = 0;

  function automatic logic [W-1:0] get_in(input int i);
    case (i)
      0:       return in_a;
      1:       return in_b;
      default: return in_c;
    endcase
  endfunction

  function automatic logic [31:0] get_rd(input int i);
    case (i)
      0:       return rd_a;
      1:       return rd_b;
      default: return rd_c;
    endcase
  endfunction

  function automatic logic get_irq(input int i);
    case (i)
      0:       return irq_a;
      1:       return irq_b;
      default: return irq_c;
    endcase
  endfunction

  function automatic logic m_irq(input int i);
    if (it[i] == 1) return |(m_ecap[i] & m_mask[i]);
    return |(m_st[i] & m_mask[i]);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs present before that edge.
  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      if (!reset_n) begin
        for (int j = 0; j < 8; j++) hist[i][j] = '0;
        m_st[i] = '0; m_std[i] = '0; m_mask[i] = '0; m_ecap[i] = '0; m_rd[i] = '0;
      end else begin
        logic [W-1:0] nst;
        logic [W-1:0] ev;
        logic [W-1:0] clr;
        nst = m_st[i];
        // A bit flips once the last dbn synchronised samples all disagree with it.
        for (int b = 0; b < W; b++) begin
          logic all_diff;
          all_diff = 1'b1;
          for (int j = 1; j <= dbn[i]; j++)
            if (hist[i][j][b] == m_st[i][b]) all_diff = 1'b0;
          if (all_diff) nst[b] = ~m_st[i][b];
        end
        case (et[i])
          0:       ev = m_st[i] & ~m_std[i];
          1:       ev = ~m_st[i] & m_std[i];
          default: ev = m_st[i] ^ m_std[i];
        endcase
        clr = '0;
        if (chipselect && !write_n && address == 2'd3) clr = (bc[i] != 0) ? writedata[W-1:0] : '1;
        case (address)
          2'd0:    m_rd[i] = 32'(m_st[i]);
          2'd2:    m_rd[i] = 32'(m_mask[i]);
          2'd3:    m_rd[i] = 32'(m_ecap[i]);
          default: m_rd[i] = '0;
        endcase
        m_ecap[i] = (m_ecap[i] & ~clr) | ev;
        if (chipselect && !write_n && address == 2'd2) m_mask[i] = writedata[W-1:0];
        m_std[i] = m_st[i];
        m_st[i]  = nst;
        for (int j = 7; j > 0; j--) hist[i][j] = hist[i][j-1];
        hist[i][0] = get_in(i);
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("cyc_rd%0d", i), get_rd(i), m_rd[i]);
      check($sformatf("cyc_irq%0d", i), {31'b0, get_irq(i)}, {31'b0, m_irq(i)});
    end
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b0;
    writedata  = d;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 8; j++) hist[i][j] = '0;
      m_st[i] = '0; m_std[i] = '0; m_mask[i] = '0; m_ecap[i] = '0; m_rd[i] = '0;
    end

    // Reset held while inputs toggle
    tick();
    in_a = 18'h3FFFF; ticks(2);
    in_a = 18'h00000; ticks(2);
    in_a = 18'h15555; ticks(2);
    check("rst_rd", rd_a, 32'h0);
    check("rst_irq", {31'b0, irq_a}, 32'h0);
    in_a = '0;
    reset_n = 1'b1;
    address = 2'd0;
    ticks(4);
    check("post_rst_rd", rd_a, 32'h0);

    // Latency with no debounce
    in_a = 18'h2A5A5;
    ticks(3);
    check("lat_early", rd_a, 32'h0);
    tick();
    check("lat_value", rd_a, 32'h0002A5A5);
    bus_write(2'd1, 32'hFFFFFFFF);
    tick();
    check("dir_reads0", rd_a, 32'h0);
    bus_write(2'd3, 32'hFFFFFFFF);
    in_a = '0;
    ticks(6);
    address = 2'd3;
    tick();
    check("no_fall_cap", rd_a, 32'h0);

    // Edge interrupt on bit 0
    bus_write(2'd2, 32'h1);
    in_a = 18'h00001;
    ticks(4);
    check("edge_irq_set", {31'b0, irq_a}, 32'h1);
    bus_write(2'd3, 32'h1);
    check("edge_irq_clr", {31'b0, irq_a}, 32'h0);
    in_a = '0;
    ticks(6);
    check("fall_no_irq", {31'b0, irq_a}, 32'h0);

    // Masked capture, then set/clear collision on bit 2
    bus_write(2'd2, 32'h0);
    in_a = 18'h00004;
    address = 2'd3;
    ticks(5);
    check("masked_ecap", rd_a, 32'h4);
    check("masked_irq", {31'b0, irq_a}, 32'h0);
    bus_write(2'd2, 32'h4);
    check("unmask_irq", {31'b0, irq_a}, 32'h1);
    bus_write(2'd3, 32'h4);
    check("w1c_irq", {31'b0, irq_a}, 32'h0);
    in_a = '0;
    ticks(6);
    in_a = 18'h00004;
    ticks(3);
    bus_write(2'd3, 32'h4);
    tick();
    check("collide_ecap", rd_a, 32'h4);
    check("collide_irq", {31'b0, irq_a}, 32'h1);

    // Debounce: short glitch rejected, long pulse accepted
    in_b = 18'h00001;
    ticks(3);
    in_b = '0;
    address = 2'd0;
    ticks(8);
    check("glitch_stable", rd_b, 32'h0);
    address = 2'd3;
    tick();
    check("glitch_ecap", rd_b, 32'h0);
    in_b = 18'h00001;
    address = 2'd0;
    ticks(6);
    check("db_latency", rd_b, 32'h0);
    tick();
    check("db_stable", rd_b, 32'h1);
    address = 2'd3;
    tick();
    check("db_ecap", rd_b, 32'h1);

    // Level interrupt and clear-all edgecapture
    bus_write(2'd2, 32'h3);
    in_c = 18'h00002;
    ticks(3);
    check("lvl_irq_on", {31'b0, irq_c}, 32'h1);
    in_c = 18'h00006;
    ticks(4);
    check("lvl_irq_hold", {31'b0, irq_c}, 32'h1);
    in_c = 18'h00004;
    ticks(4);
    check("lvl_irq_off", {31'b0, irq_c}, 32'h0);
    address = 2'd3;
    tick();
    check("any_ecap", rd_c, 32'h6);
    bus_write(2'd3, 32'h1);
    tick();
    check("clr_all", rd_c, 32'h0);

    // Reset in the middle of a debounce count
    in_b = '0;
    ticks(8);
    in_b = 18'h00001;
    ticks(3);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    address = 2'd0;
    ticks(6);
    check("rst_mid_db_early", rd_b, 32'h0);
    tick();
    check("rst_mid_db_late", rd_b, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/avalon_pio_input_irq.md
Name: avalon_pio_input_irq

Overview:
- Parametrised Avalon-MM slave input port: successor to the fixed 18-bit, read-only switch port.
- Adds a 2-flop synchroniser, an optional per-bit debounce filter, per-bit edge capture and a maskable interrupt to the Nios system.
- Sits between board-level inputs (switches, keys) and the system interconnect.
- Read latency is 1 cycle with a registered readdata.

Parameters:
- WIDTH, 18, number of input bits (1..32).
- DEBOUNCE_CYCLES, 1, consecutive stable cycles required before a bit change is accepted (>=1; 1 = no filtering).
- EDGE_TYPE, 0, edge captured: 0 rising, 1 falling, 2 any.
- IRQ_TYPE, 1, 0 = level interrupt from data, 1 = edge interrupt from edgecapture.
- BIT_CLEAR, 1, 1 = edgecapture write-1-to-clear per bit; 0 = any write to address 3 clears all bits.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous, active-low.
- address  in  2  register select.
- chipselect  in  1  slave select; qualifies writes.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- in_port  in  WIDTH  asynchronous external inputs.
- readdata  out  32  registered read data.
- irq  out  1  interrupt request, active-high.

Behaviour:
- Reset values: every register is cleared while reset_n is low, regardless of clk.
  - Cleared registers: sync1, sync2, stable, stable_d, debounce counters, irqmask, edgecapture, readdata.
  - irq = 0 after reset.
  - stable_d = 0, so inputs already high at reset release raise rising edges once they propagate.
  - Reset asserted mid-debounce discards the count.
- Synchroniser: sync1 <= in_port; sync2 <= sync1 on every clk.
- Debounce (per bit, counter width clog2(DEBOUNCE_CYCLES)+1):
  - If sync2[i]==stable[i]: cnt[i] <= 0.
  - Else if cnt[i]==DEBOUNCE_CYCLES-1: stable[i] <= sync2[i]; cnt[i] <= 0.
  - Else: cnt[i] <= cnt[i]+1.
  - A glitch shorter than DEBOUNCE_CYCLES never reaches stable.
- Latency, in_port change (sampled at edge 1) to stable: edge 2+DEBOUNCE_CYCLES.
- Edge detect: stable_d <= stable every cycle.
  - ev = stable&~stable_d (rising), ~stable&stable_d (falling), or stable^stable_d (any).
  - edgecapture[i] <= 1 on the edge after ev[i] asserts.
  - Capture is independent of irqmask.
  - Same-cycle set and clear on a bit: set wins.
- Register map, read side (readdata <= selected value on every clk, not gated by chipselect; undefined upper bits read 0):
  - addr 0: stable[WIDTH-1:0], read-only; writes ignored.
  - addr 1: reads 0; writes ignored (direction register reserved; input-only port).
  - addr 2: irqmask[WIDTH-1:0], read/write.
  - addr 3: edgecapture[WIDTH-1:0].
- Register map, write side:
  - Write occurs when chipselect && !write_n, taking effect on that clk edge.
  - addr 3 write: BIT_CLEAR=1 clears bits where writedata[i]=1; BIT_CLEAR=0 clears all bits.
  - writedata bits above WIDTH are ignored.
- Read latency: address presented in cycle k appears on readdata after edge k+1. Read-after-write to the same address returns the new value one cycle later.
- irq is combinational from registers, glitch-free since all inputs are flops:
  - IRQ_TYPE=1: irq = |(edgecapture & irqmask).
  - IRQ_TYPE=0: irq = |(stable & irqmask).
- Simultaneous events:
  - Mask write and edge capture in the same cycle: both take effect.
  - irq reflects the new values in the next cycle.

Test Plan:
- Reset: WIDTH=18, hold reset_n=0, toggle in_port -> readdata=0, irq=0; release, read addr 0 with in_port=18'h00000 -> 32'h0.
- Latency/no debounce: DEBOUNCE_CYCLES=1, in_port 0->18'h2A5A5 -> addr 0 reads 32'h0002A5A5 no earlier than 4 cycles after the change; addr 1 reads 0 after writing 32'hFFFFFFFF to it.
- Debounce: DEBOUNCE_CYCLES=4, bit 0 high for 3 cycles then low -> stable[0] stays 0 and edgecapture=0; high for 6 cycles -> stable[0]=1 and edgecapture[0]=1.
- Edge IRQ: EDGE_TYPE=0, mask=32'h1, rising edge on bit 0 -> irq=1; write 32'h1 to addr 3 -> irq=0 next cycle; falling edge on bit 0 -> irq stays 0.
- Masking/clear collision: rising edge on bit 2 with mask=0 -> edgecapture=32'h4, irq=0; write mask 32'h4 -> irq=1; write-1-clear of bit 2 in the same cycle as a new bit-2 edge -> edgecapture[2] stays 1.
- Level IRQ and BIT_CLEAR=0: IRQ_TYPE=0, mask=32'h3, in_port bit 1 high -> irq=1 until the bit drops; any write to addr 3 with edgecapture=32'h6 -> reads 0.
